// File: rtl/exp2_special_bypass.sv
// Half-precision wrapper around a fixed-latency 2^x core: special operands are
// replaced by +0.0 on issue, and their precomputed results are merged back in order.
module exp2_special_bypass #(
  parameter int BITS  = 16,
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [BITS-1:0]          a,
  output logic                     exp_in_valid,
  output logic [BITS-1:0]          exp_a,
  input  logic                     exp_out_valid,
  input  logic [BITS-1:0]          exp_c,
  output logic                     out_valid,
  output logic [BITS-1:0]          c,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     err_overflow,
  output logic                     err_underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  // Returns {bypass, value}; the top-down order resolves overlapping classes.
  function automatic logic [BITS:0] classify(input logic [BITS-1:0] x);
    logic [4:0] e;
    logic [9:0] m;
    e = x[14:10];
    m = x[9:0];
    if (e == 5'h1f && m != 10'h0)             return {1'b1, 16'h7E00};
    else if (x == 16'h7C00)                   return {1'b1, 16'h7C00};
    else if (x == 16'hFC00)                   return {1'b1, 16'h0000};
    else if (e == 5'h00)                      return {1'b1, 16'h3C00};
    else if (!x[15] && x[14:0] >= 15'h4C00)   return {1'b1, 16'h7C00};
    else if (x[15] && x[14:0] > 15'h4E40)     return {1'b1, 16'h0000};
    else                                      return {1'b0, 16'h0000};
  endfunction

  logic [BITS:0]   cls;
  logic            byp;
  logic [BITS-1:0] byp_val;
  logic            full, empty, push, pop;

  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic            byp_mem [DEPTH];
  logic [BITS-1:0] val_mem [DEPTH];

  always_comb begin
    cls     = classify(a);
    byp     = cls[BITS];
    byp_val = cls[BITS-1:0];
  end

  // A full FIFO still accepts a push when the same edge pops the head.
  assign full  = (level == LW'(DEPTH));
  assign empty = (level == '0);
  assign push  = in_valid && (!full || exp_out_valid);
  assign pop   = exp_out_valid && !empty;

  always_ff @(posedge clk) begin
    if (push) begin
      byp_mem[wr_ptr] <= byp;
      val_mem[wr_ptr] <= byp_val;
    end
  end

  // Issue and merge stages
  always_ff @(posedge clk) begin
    if (rst) begin
      exp_in_valid  <= 1'b0;
      exp_a         <= '0;
      out_valid     <= 1'b0;
      c             <= '0;
      level         <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      exp_in_valid <= push;
      if (push) begin
        exp_a  <= byp ? '0 : a;
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (in_valid && !push)
        err_overflow <= 1'b1;

      out_valid <= exp_out_valid;
      if (exp_out_valid)
        c <= (pop && byp_mem[rd_ptr]) ? val_mem[rd_ptr] : exp_c;
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      if (exp_out_valid && empty)
        err_underflow <= 1'b1;

      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule
